// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch queue and the decode stage.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [31:0] INSTR_NOP = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            misaligned;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
module fetch_queue_mem
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = $bits(fetch_entry_t),
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];

   // Contents need no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// First-word fall-through instruction queue between fetch and decode,
// emptied on redirect.
module fetch_decode_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = fetch_pkg::XLEN
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_instr,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   output logic                     out_misaligned,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * XLEN + 1;

   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt;
   logic [EW-1:0] wdata, rdata;
   logic          push, pop;

   // in_ready looks only at registered count, never at out_ready.
   assign in_ready  = (cnt != CW'(DEPTH));
   assign out_valid = (cnt != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign count     = cnt;

   assign wdata = {in_pc, in_instr, (in_pc[1:0] != 2'b00)};
   assign {out_pc, out_instr, out_misaligned} = out_valid ? rdata : '0;

   fetch_queue_mem #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue against a queue-based model.
module tb_fetch_decode_queue;
   localparam int DEPTH = 4;

   logic        clk, reset, in_valid, flush, out_ready;
   logic [31:0] in_pc, in_instr;
   logic        in_ready, out_valid, out_misaligned;
   logic [31:0] out_pc, out_instr;
   logic [2:0]  count;

   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t q[$];

   int n_tests = 0;
   int n_fail  = 0;

   fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .out_misaligned(out_misaligned), .count(count)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Advance one clock (called just after a negedge) and apply queue semantics to the model.
   task automatic cycle();
      bit do_push, do_pop;
      do_push = in_valid && (q.size() < DEPTH) && !flush;
      do_pop  = (q.size() != 0) && out_ready && !flush;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back('{in_pc, in_instr});
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 0; in_valid = 0; flush = 0; out_ready = 0; in_pc = 0; in_instr = 0;
      #3;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_tests++; if (out_pc !== 32'd0 || out_instr !== 32'd0 || out_misaligned !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_data got pc=%h instr=%h mis=%0b exp 0", out_pc, out_instr, out_misaligned); end
      @(negedge clk);
      reset = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         n_tests++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL idle_%0d got rdy=%0b vld=%0b cnt=%0d pc=%h exp 1/0/0/0", i, in_ready, out_valid, count, out_pc);
         end
      end
   endtask

   task automatic test_streaming();
      logic [31:0] instrs [3];
      instrs[0] = 32'h00500093; instrs[1] = 32'h00A00113; instrs[2] = 32'h002081B3;
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_pc = 32'(i * 4); in_instr = instrs[i];
         cycle();
         n_tests++;
         if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== instrs[i] || count !== 3'd1) begin
            n_fail++;
            $display("FAIL stream_%0d got vld=%0b pc=%h instr=%h cnt=%0d exp 1/%h/%h/1",
                     i, out_valid, out_pc, out_instr, count, 32'(i * 4), instrs[i]);
         end
      end
      in_valid = 0;
      cycle();
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_drain got=%0d exp=0", count); end
   endtask

   task automatic test_fill_stall();
      logic [31:0] heads [5];
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in_pc = 32'h10 + 32'(i * 4); in_instr = $urandom;
         cycle();
      end
      // Fetch keeps holding pc=0x20 because it was not accepted.
      n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", count); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_tests++;
         if (out_pc !== 32'h10 || count !== 3'd4) begin
            n_fail++; $display("FAIL stall_hold_%0d got pc=%h cnt=%0d exp 10/4", i, out_pc, count);
         end
      end
      heads[0] = 32'h10; heads[1] = 32'h14; heads[2] = 32'h18; heads[3] = 32'h1C; heads[4] = 32'h20;
      out_ready = 1;
      for (int j = 0; j < 5; j++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_pc !== heads[j]) begin
            n_fail++; $display("FAIL drain_%0d got vld=%0b pc=%h exp 1/%h", j, out_valid, out_pc, heads[j]);
         end
         in_valid = (j < 2);
         cycle();
         if (j == 0) begin
            n_tests++;
            if (in_ready !== 1'b1 || count !== 3'd3) begin
               n_fail++; $display("FAIL ready_after_pop got rdy=%0b cnt=%0d exp 1/3", in_ready, count);
            end
         end
      end
      in_valid = 0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
   endtask

   task automatic test_wrap();
      logic [31:0] pcs [$];
      int rounds [2];
      rounds[0] = 3; rounds[1] = 4;
      for (int r = 0; r < 2; r++) begin
         pcs.delete();
         out_ready = 0;
         for (int i = 0; i < rounds[r]; i++) begin
            in_valid = 1; in_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}; in_instr = $urandom;
            pcs.push_back(in_pc);
            cycle();
         end
         in_valid = 0; out_ready = 1;
         for (int i = 0; i < rounds[r]; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== q[0].instr) begin
               n_fail++; $display("FAIL wrap_r%0d_%0d got pc=%h instr=%h exp %h/%h", r, i, out_pc, out_instr, pcs[i], q[0].instr);
            end
            cycle();
         end
      end
      out_ready = 0;
   endtask

   task automatic test_flush();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_pc = 32'h100 + 32'(i * 4); in_instr = $urandom;
         cycle();
      end
      n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
      flush = 1; in_valid = 1; in_pc = 32'h40; out_ready = 1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_in_ready got=%0b exp=1", in_ready); end
      cycle();
      flush = 0;
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_after got cnt=%0d vld=%0b rdy=%0b exp 0/0/1", count, out_valid, in_ready);
      end
      in_valid = 1; in_pc = 32'h80; in_instr = 32'h13; out_ready = 0;
      cycle();
      in_valid = 0;
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h80 || count !== 3'd1) begin
         n_fail++; $display("FAIL flush_next_push got vld=%0b pc=%h cnt=%0d exp 1/80/1", out_valid, out_pc, count);
      end
      out_ready = 1;
      cycle();
      out_ready = 0;
   endtask

   task automatic test_misaligned_reset();
      out_ready = 0;
      in_valid = 1; in_pc = 32'h22; in_instr = $urandom;
      cycle();
      n_tests++;
      if (out_misaligned !== 1'b1 || out_pc !== 32'h22) begin
         n_fail++; $display("FAIL misaligned got mis=%0b pc=%h exp 1/22", out_misaligned, out_pc);
      end
      in_pc = 32'h24;
      cycle();
      in_valid = 0;
      n_tests++; if (count !== 3'd2 || out_misaligned !== 1'b1) begin
         n_fail++; $display("FAIL mis_hold got cnt=%0d mis=%0b exp 2/1", count, out_misaligned); end
      #2 reset = 0;
      q.delete();
      #1;
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'd0 || out_misaligned !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL async_reset got cnt=%0d vld=%0b pc=%h mis=%0b rdy=%0b exp 0/0/0/0/1",
                            count, out_valid, out_pc, out_misaligned, in_ready);
      end
      @(negedge clk);
      reset = 1;
      in_valid = 1; in_pc = 32'h30; in_instr = 32'h13;
      cycle();
      in_valid = 0;
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h30 || count !== 3'd1) begin
         n_fail++; $display("FAIL push_after_reset got vld=%0b pc=%h cnt=%0d exp 1/30/1", out_valid, out_pc, count);
      end
      out_ready = 1;
      cycle();
   endtask

   task automatic test_random();
      int errs = 0;
      logic [31:0] ep, ei;
      logic em;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_pc     = $urandom;
         in_instr  = $urandom;
         ep = (q.size() != 0) ? q[0].pc : 32'd0;
         ei = (q.size() != 0) ? q[0].instr : 32'd0;
         em = (q.size() != 0) ? (ep[1:0] != 2'b00) : 1'b0;
         n_tests++;
         if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH) ||
             out_pc !== ep || out_instr !== ei || out_misaligned !== em) begin
            n_fail++;
            if (errs < 10)
               $display("FAIL random_%0d got cnt=%0d vld=%0b rdy=%0b pc=%h instr=%h mis=%0b exp cnt=%0d pc=%h instr=%h mis=%0b",
                        i, count, out_valid, in_ready, out_pc, out_instr, out_misaligned, q.size(), ep, ei, em);
            errs++;
         end
         cycle();
      end
      flush = 0; in_valid = 0; out_ready = 0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_fill_stall();
      test_wrap();
      test_flush();
      test_misaligned_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Instruction queue between the instruction fetch unit and the decode stage.
- Captures each fetched {pc, instruction} pair and presents it to decode through a valid/ready handshake.
- Absorbs decode stalls without dropping instructions.
- Discards all buffered entries on a redirect (taken branch or jump) so that wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- XLEN, 32, width of the pc and instruction fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a valid pc/instruction this cycle.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  XLEN  address of the fetched instruction.
- in_instr  input  XLEN  fetched instruction word.
- flush  input  1  redirect: discard all contents.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  XLEN  pc of the head entry.
- out_instr  output  XLEN  instruction of the head entry.
- out_misaligned  output  1  head entry's pc[1:0] != 0.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset low, asynchronous):
  - rd_ptr, wr_ptr and count cleared to 0.
  - in_ready=1, out_valid=0, out_pc=0, out_instr=0, out_misaligned=0.
  - Storage contents are don't-care.
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- in_ready = (count != DEPTH). It depends only on registered state and never on out_ready, so there is no combinational path from in to out. A full queue therefore accepts no push, even in a cycle that pops.
- out_valid = (count != 0). out_pc, out_instr and out_misaligned are driven from storage[rd_ptr] and are first-word fall-through.
- Latency:
  - An entry pushed at edge N is visible on the outputs after edge N; decode can consume it in cycle N+1.
  - Minimum fetch-to-decode latency is 1 cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is the only full/empty indicator.
- out_misaligned is stored per entry as (in_pc[1:0] != 2'b00) at push time. The queue does not otherwise alter or interpret the instruction.
- Flush:
  - At the next edge, count=0 and rd_ptr=wr_ptr=0.
  - Any push or pop presented in the same cycle is ignored.
  - out_valid is 0 from the following cycle.
  - in_ready is 1 from the following cycle. During the flush cycle it still reflects the current count.
- Flush has priority over push and pop. Reset has priority over everything.
- Output stability: while out_valid && !out_ready && !flush, out_pc, out_instr and out_misaligned must not change.
- Reset asserted mid-operation: the queue empties immediately (asynchronously). The first push is accepted on the first edge after reset deasserts.

Decomposition:
- Shared package fetch_pkg:
  - XLEN default.
  - INSTR_NOP constant 32'h00000013.
  - Typedef fetch_entry_t {pc, instr, misaligned}. This typedef is reused by the decode stage.
- One sub-module, fetch_queue_mem: DEPTH x entry storage with a synchronous write port and an asynchronous read port.
- Pointer, count and handshake control stay in fetch_decode_queue.

Test Plan:
- Reset then idle: with reset low, check in_ready=1, out_valid=0, count=0; release reset and hold for 10 cycles; the outputs must not change.
- Streaming:
  - Stimulus: push pc=0x0,0x4,0x8 with instr 0x00500093,0x00A00113,0x002081B3; out_ready=1 throughout.
  - Required: each pair appears on out exactly 1 cycle after its push, in order, and count never exceeds 1.
- Fill and stall:
  - Stimulus: out_ready=0; push 5 entries at pc=0x10..0x20.
  - Required: the first 4 are accepted, count=4, in_ready=0; the 5th is held by fetch; out holds pc=0x10 stable.
  - Then raise out_ready: entries drain as 0x10,0x14,0x18,0x1C, and in_ready returns 1 the cycle after the first pop.
- Wrap-around: 3 pushes, 3 pops, then 4 pushes and 4 pops (pointers wrap); the output order must match the push order exactly.
- Flush with traffic:
  - Stimulus: count=3, then in the same cycle assert flush, in_valid with pc=0x40 and out_ready.
  - Required: next cycle count=0 and out_valid=0, pc=0x40 is not stored, and no pop is counted.
  - A following push of pc=0x80 appears on out next cycle.
- Misaligned and async reset:
  - Push pc=0x22: out_misaligned=1 with it at the head.
  - Assert reset mid-cycle while count=2: count=0 and out_valid=0 immediately, without waiting for a clock edge.
